// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port SISC memory among three requesters
// (0 = instruction fetch, 1 = CPU data LOD/STR/SWP, 2 = debug loader).
// Each transaction runs IDLE -> ACCESS -> RESP. Requesters win in round-robin
// order. A lock bit lets the current winner keep the memory for its next
// access, which makes SWP atomic. All outputs are registered.
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [2:0]    lock,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic          r_lock_vld, w_lock_vld_nxt;
    logic [1:0]    r_lock_owner, w_lock_owner_nxt;
    logic [2:0]    r_gnt, w_gnt_nxt;
    logic [2:0]    r_done, w_done_nxt;
    logic          r_we, w_we_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_mem_en, w_mem_en_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_rdata, w_rdata_nxt;

    // Padded to 4 bits so a 2-bit requester index never selects out of range.
    logic [3:0]    w_req_pad;
    logic [3:0]    w_we_pad;
    logic [3:0]    w_lock_pad;
    logic [1:0]    w_ord0, w_ord1, w_ord2;
    logic          w_win_vld;
    logic [1:0]    w_win_idx;
    logic          w_win_we;
    logic          w_win_lock;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;
    logic [2:0]    w_win_onehot;

    function automatic logic [1:0] rr_inc(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign w_req_pad  = {1'b0, req};
    assign w_we_pad   = {1'b0, we};
    assign w_lock_pad = {1'b0, lock};

    // Search order for this IDLE cycle: rr_ptr first, then the two after it.
    always_comb begin
        w_ord0 = r_rr_ptr;
        w_ord1 = rr_inc(r_rr_ptr);
        w_ord2 = rr_inc(w_ord1);
    end

    // Winner selection: a pending lock owner beats round-robin order.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        if (r_lock_vld && w_req_pad[r_lock_owner]) begin
            w_win_vld = 1'b1;
            w_win_idx = r_lock_owner;
        end else if (w_req_pad[w_ord0]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_ord0;
        end else if (w_req_pad[w_ord1]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_ord1;
        end else if (w_req_pad[w_ord2]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_ord2;
        end
    end

    // Route the winner's access attributes to the transaction latch inputs.
    always_comb begin
        w_win_addr  = addr0;
        w_win_wdata = wdata0;
        case (w_win_idx)
            2'd1: begin
                w_win_addr  = addr1;
                w_win_wdata = wdata1;
            end
            2'd2: begin
                w_win_addr  = addr2;
                w_win_wdata = wdata2;
            end
            default: ;
        endcase
        w_win_we     = w_we_pad[w_win_idx];
        w_win_lock   = w_lock_pad[w_win_idx];
        w_win_onehot = 3'b001 << w_win_idx;
    end

    // Next-state and next-output logic for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_vld_nxt   = r_lock_vld;
        w_lock_owner_nxt = r_lock_owner;
        w_gnt_nxt        = r_gnt;
        w_done_nxt       = '0;
        w_we_nxt         = r_we;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_rdata_nxt      = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_ACCESS;
                    w_gnt_nxt   = w_win_onehot;
                    w_we_nxt    = w_win_we;
                    w_addr_nxt  = w_win_addr;
                    w_wdata_nxt = w_win_wdata;
                    if (w_win_lock) begin
                        // Locked grant keeps rr_ptr where it is.
                        w_lock_vld_nxt   = 1'b1;
                        w_lock_owner_nxt = w_win_idx;
                    end else begin
                        w_lock_vld_nxt = 1'b0;
                        w_rr_ptr_nxt   = rr_inc(w_win_idx);
                    end
                end else begin
                    // No request at all: any lock owner has dropped out.
                    w_gnt_nxt      = '0;
                    w_lock_vld_nxt = 1'b0;
                end
            end
            S_ACCESS: begin
                w_state_nxt     = S_RESP;
                w_mem_en_nxt    = 1'b1;
                w_mem_we_nxt    = r_we;
                w_mem_addr_nxt  = r_addr;
                w_mem_wdata_nxt = r_wdata;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = r_gnt;
                w_gnt_nxt   = '0;
                if (!r_we) begin
                    w_rdata_nxt = mem_rdata;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_lock_vld   <= 1'b0;
            r_lock_owner <= '0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock_vld   <= w_lock_vld_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_gnt        <= w_gnt_nxt;
            r_done       <= w_done_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rdata      <= w_rdata_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
